// File: rtl/fifo_wr_adapter_pkg.sv
// Shared definitions for the write-side FIFO source adapter:
// default widths and the width helpers used by the queue pointers,
// buf_level and hwm.
package fifo_wr_adapter_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BUF_DEPTH = 4;
    localparam int DEF_CNT_W     = 16;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Queue pointer width: one extra bit to tell full from empty.
    function automatic int ptr_w_f(input int depth);
        return clog2_f(depth) + 1;
    endfunction

    // Width of a word count covering queue plus output register.
    function automatic int lvl_w_f(input int depth);
        return clog2_f(depth + 1) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_adapter_wr_skid_queue.sv
// wr_skid_queue: circular buffer of DEPTH entries with push/pop,
// occupancy count and head data. Pointers carry one wrap bit.
module wr_skid_queue
    import fifo_wr_adapter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                        clk_w,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           head_data,
    output logic [ptr_w_f(DEPTH)-1:0]   count,
    output logic                        empty,
    output logic                        full
);

    localparam int PTR_W = ptr_w_f(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Pointer update; contents are discarded by simply zeroing the pointers.
    always_ff @(posedge clk_w or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; entries need no reset because pointers define validity.
    always_ff @(posedge clk_w) begin
        if (push) begin
            mem_r[wr_ptr_r[PTR_W-2:0]] <= push_data;
        end
    end

    // Status and head data derived from the pointers.
    always_comb begin
        head_data = mem_r[rd_ptr_r[PTR_W-2:0]];
        count     = wr_ptr_r - rd_ptr_r;
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                    (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0]);
    end

endmodule

// File: rtl/fifo_wr_adapter.sv
// fifo_wr_adapter: write-side source adapter for the async FIFO (clk_w domain).
// Buffers a valid/ready stream in a skid queue plus one output register and
// drives wr_en/data_w while honouring the FIFO full flag. Zero words can be
// dropped when the path is congested (FILTER_ZERO).
// Build option: define FIFO_WR_ADAPTER_STAT_EN to make drop_cnt and hwm live;
// otherwise both read as 0 and their registers are not built.
module fifo_wr_adapter
    import fifo_wr_adapter_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BUF_DEPTH   = DEF_BUF_DEPTH,
    parameter int FILTER_ZERO = 1,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                           clk_w,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    input  logic                           full,
    output logic                           wr_en,
    output logic [DATA_W-1:0]              data_w,
    output logic [lvl_w_f(BUF_DEPTH)-1:0]  buf_level,
    output logic [CNT_W-1:0]               drop_cnt,
    output logic [lvl_w_f(BUF_DEPTH)-1:0]  hwm
);

    localparam int PTR_W = ptr_w_f(BUF_DEPTH);
    localparam int LVL_W = lvl_w_f(BUF_DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(BUF_DEPTH);

    logic              alive_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] data_r;

    logic [DATA_W-1:0] q_head_s;
    logic [PTR_W-1:0]  q_count_s;
    logic              q_empty_s;
    logic              q_full_s;

    logic              filt_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              drop_s;
    logic              keep_s;
    logic              wr_en_s;
    logic              load_s;
    logic              pop_s;
    logic              bypass_s;
    logic              push_s;
    logic [LVL_W-1:0]  buf_level_s;

    wr_skid_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_queue (
        .clk_w     (clk_w),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (in_data),
        .pop       (pop_s),
        .head_data (q_head_s),
        .count     (q_count_s),
        .empty     (q_empty_s),
        .full      (q_full_s)
    );

    // Handshake, filter and routing decisions for this cycle.
    always_comb begin
        filt_s      = (FILTER_ZERO != 0) && (in_data == {DATA_W{1'b0}});
        in_ready_s  = alive_r & ((q_count_s < DEPTH_C) | filt_s);
        accept_s    = in_valid & in_ready_s;
        // A zero word only drops when nothing can move: FIFO full and queue full.
        drop_s      = accept_s & filt_s & full & q_full_s;
        keep_s      = accept_s & ~drop_s;
        wr_en_s     = out_valid_r & ~full;
        load_s      = ~out_valid_r | wr_en_s;
        pop_s       = load_s & ~q_empty_s;
        // Bypass only when the queue is empty, so ordering is preserved.
        bypass_s    = load_s & q_empty_s & keep_s;
        push_s      = keep_s & ~bypass_s;
        buf_level_s = LVL_W'(q_count_s) + LVL_W'(out_valid_r);
    end

    // in_ready stays low during reset and rises on the first edge after release.
    always_ff @(posedge clk_w or negedge reset_n) begin
        if (!reset_n) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    // Output register: reload when empty or being written; data held otherwise.
    always_ff @(posedge clk_w or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            data_r      <= {DATA_W{1'b0}};
        end else if (load_s) begin
            if (pop_s) begin
                out_valid_r <= 1'b1;
                data_r      <= q_head_s;
            end else if (bypass_s) begin
                out_valid_r <= 1'b1;
                data_r      <= in_data;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef FIFO_WR_ADAPTER_STAT_EN
    localparam logic [LVL_W-1:0] LVL_MAX_C = LVL_W'(BUF_DEPTH + 1);

    logic [CNT_W-1:0] drop_cnt_r;
    logic [LVL_W-1:0] hwm_r;

    // Saturating count of discarded zero words.
    always_ff @(posedge clk_w or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // High-water mark of buf_level, clamped to total capacity.
    always_ff @(posedge clk_w or negedge reset_n) begin
        if (!reset_n) begin
            hwm_r <= {LVL_W{1'b0}};
        end else if (buf_level_s > hwm_r) begin
            hwm_r <= (buf_level_s > LVL_MAX_C) ? LVL_MAX_C : buf_level_s;
        end
    end

    assign drop_cnt = drop_cnt_r;
    assign hwm      = hwm_r;
`else
    assign drop_cnt = {CNT_W{1'b0}};
    assign hwm      = {LVL_W{1'b0}};
`endif

    assign in_ready  = in_ready_s;
    assign wr_en     = wr_en_s;
    assign data_w    = data_r;
    assign buf_level = buf_level_s;

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Self-checking bench for fifo_wr_adapter (DATA_W=8, BUF_DEPTH=4, FILTER_ZERO=1).
// Statistics expectations follow FIFO_WR_ADAPTER_STAT_EN.
module tb_fifo_wr_adapter;

`ifdef FIFO_WR_ADAPTER_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk_w    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        full     = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  data_w;
    logic [3:0]  buf_level;
    logic [15:0] drop_cnt;
    logic [3:0]  hwm;

    int checks = 0;
    int errors = 0;

    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       e_rdy;
        logic       e_wr;
        logic [7:0] e_dat;
        logic [3:0] e_lvl;
    } vec_t;

    vec_t vecs[36];

    fifo_wr_adapter #(
        .DATA_W      (8),
        .BUF_DEPTH   (4),
        .FILTER_ZERO (1),
        .CNT_W       (16)
    ) dut (
        .clk_w     (clk_w),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .full      (full),
        .wr_en     (wr_en),
        .data_w    (data_w),
        .buf_level (buf_level),
        .drop_cnt  (drop_cnt),
        .hwm       (hwm)
    );

    always #5 clk_w = ~clk_w;

    // Record every word the FIFO would capture.
    always @(negedge clk_w) begin
        if (reset_n && wr_en) begin
            log_q.push_back(data_w);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name);
        bit ok;
        ok = (log_q.size() == exp_q.size());
        if (ok) begin
            for (int i = 0; i < log_q.size(); i++) begin
                if (log_q[i] !== exp_q[i]) ok = 1'b0;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%p required=%p", name, log_q, exp_q);
        end
    endtask

    task automatic step();
        @(posedge clk_w);
        #1;
    endtask

    initial begin
        int next_word;
        int max_lvl;
        bit accepted;
        bit drained;

        //               v     d      f     rdy   wr    dat    lvl
        vecs[0]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 4'd0};
        vecs[3]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h5A, 4'd0};
        vecs[4]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h01, 4'd1};
        vecs[5]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h01, 4'd2};
        vecs[6]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h01, 4'd3};
        vecs[7]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h01, 4'd4};
        vecs[8]  = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 8'h01, 4'd5};
        vecs[9]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h01, 4'd5};
        vecs[10] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h02, 4'd4};
        vecs[11] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h03, 4'd4};
        vecs[12] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h04, 4'd3};
        vecs[13] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h05, 4'd2};
        vecs[14] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h06, 4'd1};
        vecs[15] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h06, 4'd0};
        vecs[16] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h06, 4'd0};
        vecs[17] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 8'h11, 4'd1};
        vecs[18] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 8'h11, 4'd2};
        vecs[19] = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 8'h11, 4'd3};
        vecs[20] = '{1'b1, 8'h15, 1'b1, 1'b1, 1'b0, 8'h11, 4'd4};
        vecs[21] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 4'd5};
        vecs[22] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 4'd5};
        vecs[23] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 4'd5};
        vecs[24] = '{1'b1, 8'h16, 1'b1, 1'b0, 1'b0, 8'h11, 4'd5};
        vecs[25] = '{1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h11, 4'd5};
        vecs[26] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h12, 4'd4};
        vecs[27] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h13, 4'd3};
        vecs[28] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h14, 4'd2};
        vecs[29] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h15, 4'd1};
        vecs[30] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h15, 4'd0};
        vecs[31] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h15, 4'd0};
        vecs[32] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 4'd1};
        vecs[33] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 4'd1};
        vecs[34] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'h00, 4'd1};
        vecs[35] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_data_w", data_w, 0);
        chk("rst_buf_level", buf_level, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_hwm", hwm, 0);
        @(negedge clk_w);
        reset_n = 1'b1;
        step();
        chk("ready_after_release", in_ready, 1);

        // Directed vector table
        for (int i = 0; i < 36; i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            full     = vecs[i].f;
            @(negedge clk_w);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].e_wr);
            chk($sformatf("vec%0d_data_w", i), data_w, vecs[i].e_dat);
            chk($sformatf("vec%0d_buf_level", i), buf_level, vecs[i].e_lvl);
            step();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_q = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00, 8'h00};
        chk_log("table_write_order");
        chk("drop_cnt_after_table", drop_cnt, STAT ? 3 : 0);
        chk("hwm_after_table", hwm, STAT ? 5 : 0);

        // Continuous stream with full toggling every cycle
        log_q.delete();
        exp_q.delete();
        next_word = 8'h20;
        max_lvl   = 0;
        for (int cyc = 0; cyc < 200 && next_word < 8'h40; cyc++) begin
            in_valid = 1'b1;
            in_data  = next_word[7:0];
            full     = cyc[0];
            @(negedge clk_w);
            if (int'(buf_level) > max_lvl) max_lvl = int'(buf_level);
            accepted = in_ready;
            step();
            if (accepted) begin
                exp_q.push_back(next_word[7:0]);
                next_word++;
            end
        end
        in_valid = 1'b0;
        full     = 1'b0;
        drained  = 1'b0;
        for (int cyc = 0; cyc < 20 && !drained; cyc++) begin
            @(negedge clk_w);
            if (buf_level == 4'd0) drained = 1'b1;
            step();
        end
        chk("toggle_all_sent", next_word, 8'h40);
        chk("toggle_drained", drained, 1);
        chk("toggle_level_bound", max_lvl <= 5, 1);
        chk_log("toggle_write_order");

        // Reset with words buffered
        log_q.delete();
        exp_q.delete();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h81 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk_w);
        chk("prereset_level", buf_level, 3);
        step();
        full    = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_buf_level", buf_level, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_data_w", data_w, 0);
        @(negedge clk_w);
        reset_n = 1'b1;
        step();
        step();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        @(negedge clk_w);
        chk("postrst_wr_en", wr_en, 1);
        chk("postrst_data_w", data_w, 8'hA5);
        step();
        step();
        step();
        exp_q = '{8'hA5};
        chk_log("postrst_write_order");
        chk("postrst_drop_cnt", drop_cnt, 0);
        chk("postrst_hwm", hwm, STAT ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
